bus_result_fifo: RTL

- Downstream stage of the 16x16 operand bus. Captures each 32-bit `result` word on the cycle the bus asserts its ready strobe.
- Buffers captured words in a small FIFO and drains them to a consumer over a valid/ready handshake.
- Keeps a running wrap-around sum of accepted results, an occupancy count and a sticky overflow flag for software/debug.

---
 rtl/bus_result_fifo.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_result_fifo.sv
// bus_result_fifo
// ----------------
// Downstream stage of the 16x16 operand bus. Each cycle the bus raises
// in_ready, the 32-bit in_result word is captured into a small FIFO. The
// FIFO drains to a consumer in first-word-fall-through fashion. The block
// also keeps a wrap-around sum of accepted words, an occupancy count and a
// sticky overflow flag.
//
// Handshake: a word moves to the consumer on every posedge where
// out_valid=1 and out_ready=1. out_valid and out_data depend only on
// registered state, so they never combinationally follow out_ready or
// in_ready. The input side cannot be stalled. A strobe that arrives while
// the FIFO is full and no pop happens in the same cycle is dropped, and
// overflow is set.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   in_ready   bus strobe qualifying in_result
//   in_result  32-bit bus product word
//   out_data   head-of-FIFO word (valid while out_valid=1)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_data this cycle
//   acc_clear  synchronous clear of acc_sum
//   acc_sum    running sum of accepted words, modulo 2^ACC_W
//   level      occupancy, 0..DEPTH
//   overflow   sticky drop indicator
//   ovf_clear  clears overflow (a same-cycle drop takes priority)
module bus_result_fifo #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_ready,
  input  logic [31:0]                in_result,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       acc_clear,
  output logic [ACC_W-1:0]           acc_sum,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [ACC_W-1:0] r_acc;
  logic          r_ovf;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Full/empty come from the level counter. The pointers alias when the
  // FIFO is either empty or full, so they cannot decide this on their own.
  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = (r_level != '0) && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
  assign w_push = in_ready && (!w_full || w_pop);
  assign w_drop = in_ready && !w_push;

  // Storage is not reset. Its contents only matter behind a valid level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // When acc_clear and an accepted push coincide, the sum restarts from
  // the new word instead of from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clear) begin
      r_acc <= w_push ? ACC_W'(in_result) : '0;
    end else if (w_push) begin
      r_acc <= r_acc + ACC_W'(in_result);
    end
  end

  // A drop takes priority over ovf_clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clear) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_level != '0);
  assign acc_sum   = r_acc;
  assign level     = r_level;
  assign overflow  = r_ovf;

endmodule
